// File: rtl/pipe_control_unit.sv
// WISC-S15 pipelined control: opcode decode, ID/EX/MEM/WB control
// registers, RAW hazard stall, redirect flush and sticky illegal flag.
module pipe_control_unit #(
  parameter int REG_ADDR_W = 4,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [3:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  stall_id,
  output logic                  flush,
  output logic                  ex_valid,
  output logic [2:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_sign_ext_sel,
  output logic                  ex_reg_rt_src,
  output logic                  ex_data_reg,
  output logic                  ex_call,
  output logic                  ex_rtrn,
  output logic                  ex_branch,
  output logic                  ex_load_half,
  output logic                  ex_half_spec,
  output logic                  mem_valid,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic                  mem_reg_to_mem,
  output logic                  wb_valid,
  output logic                  wb_RegWrite,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  err_illegal
);

  typedef struct packed {
    logic                  valid;
    logic [2:0]            alu_op;
    logic                  alu_src;
    logic                  sign_ext_sel;
    logic                  reg_rt_src;
    logic                  data_reg;
    logic                  call;
    logic                  rtrn;
    logic                  branch;
    logic                  load_half;
    logic                  half_spec;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_to_mem;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic                  valid;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_to_mem;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;
  logic    err_q,    err_d;

  id_ex_t dec;
  logic   uses_rs, uses_rt;
  logic   op_inc, op_lw, op_sw, op_lhb;
  logic   op_llb, op_b, op_call, op_ret;
  logic   op_ill;

  assign op_inc  = (opcode == 4'h4);
  assign op_lw   = (opcode == 4'h8);
  assign op_sw   = (opcode == 4'h9);
  assign op_lhb  = (opcode == 4'hA);
  assign op_llb  = (opcode == 4'hB);
  assign op_b    = (opcode == 4'hC);
  assign op_call = (opcode == 4'hD);
  assign op_ret  = (opcode == 4'hE);
  assign op_ill  = (opcode == 4'hF);

  // Decode the ID opcode; illegal or empty slots become a bubble
  always_comb begin
    dec     = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    if (id_valid && !op_ill) begin
      dec.valid     = 1'b1;
      dec.alu_op    = opcode[2:0];
      dec.reg_write = 1'b1;
      dec.rd        = rd;
      uses_rs = ~opcode[3] | op_lw | op_sw | op_ret;
      uses_rt = (opcode[3:2] == 2'b00) | op_sw
              | op_lhb | op_llb;
      unique case (1'b1)
        op_inc: begin
          dec.alu_src      = 1'b1;
          dec.sign_ext_sel = 1'b1;
        end
        op_lw: begin
          dec.alu_src      = 1'b1;
          dec.sign_ext_sel = 1'b1;
          dec.data_reg     = 1'b1;
          dec.mem_read     = 1'b1;
          dec.mem_to_reg   = 1'b1;
        end
        op_sw: begin
          dec.alu_op       = 3'b000;
          dec.alu_src      = 1'b1;
          dec.sign_ext_sel = 1'b1;
          dec.reg_rt_src   = 1'b1;
          dec.data_reg     = 1'b1;
          dec.mem_write    = 1'b1;
          dec.reg_to_mem   = 1'b1;
          dec.reg_write    = 1'b0;
        end
        op_lhb: begin
          dec.reg_rt_src   = 1'b1;
          dec.load_half    = 1'b1;
        end
        op_llb: begin
          dec.reg_rt_src   = 1'b1;
          dec.load_half    = 1'b1;
          dec.half_spec    = 1'b1;
        end
        op_b: begin
          dec.sign_ext_sel = 1'b1;
          dec.branch       = 1'b1;
          dec.reg_write    = 1'b0;
        end
        op_call: begin
          dec.alu_op       = 3'b000;
          dec.call         = 1'b1;
          dec.mem_write    = 1'b1;
          dec.reg_to_mem   = 1'b1;
        end
        op_ret: begin
          dec.alu_op       = 3'b000;
          dec.rtrn         = 1'b1;
          dec.mem_read     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic ex_wr, mem_wr;
  logic hit_ex, hit_mem;
  logic hazard, redirect;

  // RAW hazard detection and redirect; WB is bypassed by the regfile
  always_comb begin
    ex_wr  = id_ex_q.valid & id_ex_q.reg_write
           & (id_ex_q.rd != '0);
    mem_wr = ex_mem_q.valid & ex_mem_q.reg_write
           & (ex_mem_q.rd != '0);
    hit_ex  = (uses_rs & (rs == id_ex_q.rd))
            | (uses_rt & (rt == id_ex_q.rd));
    hit_mem = (uses_rs & (rs == ex_mem_q.rd))
            | (uses_rt & (rt == ex_mem_q.rd));
    if (FWD_EN)
      hazard = dec.valid & ex_wr & id_ex_q.mem_read & hit_ex;
    else
      hazard = dec.valid & ((ex_wr & hit_ex) | (mem_wr & hit_mem));
    redirect = id_ex_q.valid
             & ((id_ex_q.branch & branch_taken)
             | id_ex_q.call | id_ex_q.rtrn);
    stall_id = mem_busy | (~redirect & hazard);
    flush    = ~mem_busy & redirect;
  end

  // Next-state for the stage registers; mem_busy freezes everything
  always_comb begin
    id_ex_d  = id_ex_q;
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    err_d    = err_q;
    if (!mem_busy) begin
      ex_mem_d.valid      = id_ex_q.valid;
      ex_mem_d.mem_read   = id_ex_q.mem_read;
      ex_mem_d.mem_write  = id_ex_q.mem_write;
      ex_mem_d.reg_to_mem = id_ex_q.reg_to_mem;
      ex_mem_d.reg_write  = id_ex_q.reg_write;
      ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
      ex_mem_d.rd         = id_ex_q.rd;
      mem_wb_d.valid      = ex_mem_q.valid;
      mem_wb_d.reg_write  = ex_mem_q.reg_write;
      mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
      mem_wb_d.rd         = ex_mem_q.rd;
      if (redirect || hazard) begin
        id_ex_d = '0;
      end else begin
        id_ex_d = dec;
        err_d   = err_q | (id_valid & op_ill);
      end
    end
  end

  // Pipeline and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      err_q    <= 1'b0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      err_q    <= err_d;
    end
  end

  assign ex_valid        = id_ex_q.valid;
  assign ex_alu_op       = id_ex_q.alu_op;
  assign ex_alu_src      = id_ex_q.alu_src;
  assign ex_sign_ext_sel = id_ex_q.sign_ext_sel;
  assign ex_reg_rt_src   = id_ex_q.reg_rt_src;
  assign ex_data_reg     = id_ex_q.data_reg;
  assign ex_call         = id_ex_q.call;
  assign ex_rtrn         = id_ex_q.rtrn;
  assign ex_branch       = id_ex_q.branch;
  assign ex_load_half    = id_ex_q.load_half;
  assign ex_half_spec    = id_ex_q.half_spec;
  assign mem_valid       = ex_mem_q.valid;
  assign mem_MemRead     = ex_mem_q.mem_read;
  assign mem_MemWrite    = ex_mem_q.mem_write;
  assign mem_reg_to_mem  = ex_mem_q.reg_to_mem;
  assign wb_valid        = mem_wb_q.valid;
  assign wb_RegWrite     = mem_wb_q.reg_write;
  assign wb_mem_to_reg   = mem_wb_q.mem_to_reg;
  assign wb_rd           = mem_wb_q.rd;
  assign err_illegal     = err_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: forwarding and
// non-forwarding instances, scoreboarded stage outputs.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] opcode, rs, rt, rd;
  logic       branch_taken, mem_busy;

  logic [12:0] ex1, ex0;
  logic [3:0]  mem1, mem0;
  logic [6:0]  wb1, wb0;
  logic        stall1, stall0, flush1, flush0;
  logic        err1, err0;

  always #5 clk = ~clk;

  pipe_control_unit #(.REG_ADDR_W(4), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_id(stall1), .flush(flush1),
    .ex_valid(ex1[12]), .ex_alu_op(ex1[11:9]),
    .ex_alu_src(ex1[8]), .ex_sign_ext_sel(ex1[7]),
    .ex_reg_rt_src(ex1[6]), .ex_data_reg(ex1[5]),
    .ex_call(ex1[4]), .ex_rtrn(ex1[3]),
    .ex_branch(ex1[2]), .ex_load_half(ex1[1]),
    .ex_half_spec(ex1[0]),
    .mem_valid(mem1[3]), .mem_MemRead(mem1[2]),
    .mem_MemWrite(mem1[1]), .mem_reg_to_mem(mem1[0]),
    .wb_valid(wb1[6]), .wb_RegWrite(wb1[5]),
    .wb_mem_to_reg(wb1[4]), .wb_rd(wb1[3:0]),
    .err_illegal(err1)
  );

  pipe_control_unit #(.REG_ADDR_W(4), .FWD_EN(1'b0)) u_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_id(stall0), .flush(flush0),
    .ex_valid(ex0[12]), .ex_alu_op(ex0[11:9]),
    .ex_alu_src(ex0[8]), .ex_sign_ext_sel(ex0[7]),
    .ex_reg_rt_src(ex0[6]), .ex_data_reg(ex0[5]),
    .ex_call(ex0[4]), .ex_rtrn(ex0[3]),
    .ex_branch(ex0[2]), .ex_load_half(ex0[1]),
    .ex_half_spec(ex0[0]),
    .mem_valid(mem0[3]), .mem_MemRead(mem0[2]),
    .mem_MemWrite(mem0[1]), .mem_reg_to_mem(mem0[0]),
    .wb_valid(wb0[6]), .wb_RegWrite(wb0[5]),
    .wb_mem_to_reg(wb0[4]), .wb_rd(wb0[3:0]),
    .err_illegal(err0)
  );

  typedef struct packed {
    logic [12:0] ex;
    logic [3:0]  mem;
    logic [6:0]  wb;
  } ent_t;

  ent_t sb[$];
  ent_t p_ex, p_mem, p_wb;
  int   checks = 0;
  int   errors = 0;
  bit   sel = 1'b1;
  bit   exp_err = 1'b0;

  logic [12:0] ex_o;
  logic [3:0]  mem_o;
  logic [6:0]  wb_o;
  logic        stall_o, flush_o, err_o;

  assign ex_o    = sel ? ex1 : ex0;
  assign mem_o   = sel ? mem1 : mem0;
  assign wb_o    = sel ? wb1 : wb0;
  assign stall_o = sel ? stall1 : stall0;
  assign flush_o = sel ? flush1 : flush0;
  assign err_o   = sel ? err1 : err0;

  function automatic ent_t ref_dec(input logic [3:0] op,
                                   input logic [3:0] d);
    ent_t r;
    logic [2:0] a;
    bit as, se, rts, dr, ca, rt_, br, lh, hs;
    bit mr, mw, rm, rw, m2r;
    a = op[2:0];
    {as, se, rts, dr, ca, rt_, br, lh, hs} = '0;
    {mr, mw, rm, m2r} = '0;
    rw = 1'b1;
    case (op)
      4'h4: begin as = 1; se = 1; end
      4'h8: begin as = 1; se = 1; dr = 1; mr = 1; m2r = 1; end
      4'h9: begin
        a = 3'b000; as = 1; se = 1; rts = 1; dr = 1;
        mw = 1; rm = 1; rw = 0;
      end
      4'hA: begin rts = 1; lh = 1; end
      4'hB: begin rts = 1; lh = 1; hs = 1; end
      4'hC: begin se = 1; br = 1; rw = 0; end
      4'hD: begin a = 3'b000; ca = 1; mw = 1; rm = 1; end
      4'hE: begin a = 3'b000; rt_ = 1; mr = 1; end
      default: ;
    endcase
    r.ex  = {1'b1, a, as, se, rts, dr, ca, rt_, br, lh, hs};
    r.mem = {1'b1, mr, mw, rm};
    r.wb  = {1'b1, rw, m2r, d};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit v, input logic [3:0] op,
                     input logic [3:0] s, input logic [3:0] t,
                     input logic [3:0] d);
    id_valid = v; opcode = op; rs = s; rt = t; rd = d;
  endtask

  task automatic step(input string tag, input bit es,
                      input bit ef, input ent_t nx);
    ent_t e;
    #1;
    chk({tag, "/stall"}, 32'(stall_o), 32'(es));
    chk({tag, "/flush"}, 32'(flush_o), 32'(ef));
    sb.push_back(mem_busy ? p_ex : nx);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!mem_busy) begin
      p_wb  = p_mem;
      p_mem = p_ex;
    end
    p_ex = e;
    chk({tag, "/ex"},  32'(ex_o),  32'(p_ex.ex));
    chk({tag, "/mem"}, 32'(mem_o), 32'(p_mem.mem));
    chk({tag, "/wb"},  32'(wb_o),  32'(p_wb.wb));
    chk({tag, "/err"}, 32'(err_o), 32'(exp_err));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    drv(0, 4'h0, 4'h0, 4'h0, 4'h0);
    branch_taken = 1'b0;
    mem_busy = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "/ex"},    32'(ex_o),    32'd0);
    chk({tag, "/mem"},   32'(mem_o),   32'd0);
    chk({tag, "/wb"},    32'(wb_o),    32'd0);
    chk({tag, "/stall"}, 32'(stall_o), 32'd0);
    chk({tag, "/flush"}, 32'(flush_o), 32'd0);
    chk({tag, "/err"},   32'(err_o),   32'd0);
    rst = 1'b0;
    p_ex = '0; p_mem = '0; p_wb = '0;
    exp_err = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 4'h0, 4'h0, 4'h0, 4'h0);
    branch_taken = 1'b0;
    mem_busy = 1'b0;

    sel = 1'b1;
    do_reset("rst0");

    for (int op = 0; op < 15; op++) begin
      drv(1, 4'(op), 4'd1, 4'd2, 4'(op + 3));
      step($sformatf("sweep%0h", op), 0, 0,
           ref_dec(4'(op), 4'(op + 3)));
      if (op == 13 || op == 14) begin
        drv(0, 4'h0, 4'h0, 4'h0, 4'h0);
        step($sformatf("redir%0h", op), 0, 1, '0);
      end
    end
    drv(0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) step("drain", 0, 0, '0);

    drv(1, 4'h8, 4'd1, 4'd2, 4'd3);
    step("lu_lw", 0, 0, ref_dec(4'h8, 4'd3));
    drv(1, 4'h0, 4'd3, 4'd4, 4'd6);
    step("lu_stall", 1, 0, '0);
    step("lu_go", 0, 0, ref_dec(4'h0, 4'd6));
    drv(1, 4'h8, 4'd1, 4'd2, 4'd0);
    step("lw_r0", 0, 0, ref_dec(4'h8, 4'd0));
    drv(1, 4'h0, 4'd0, 4'd0, 4'd6);
    step("r0_nostall", 0, 0, ref_dec(4'h0, 4'd6));
    drv(1, 4'h0, 4'd1, 4'd2, 4'd5);
    step("fwd_add", 0, 0, ref_dec(4'h0, 4'd5));
    drv(1, 4'h1, 4'd1, 4'd5, 4'd6);
    step("fwd_nostall", 0, 0, ref_dec(4'h1, 4'd6));
    drv(0, 4'h0, 4'h0, 4'h0, 4'h0);
    step("drain", 0, 0, '0);

    drv(1, 4'hC, 4'd0, 4'd0, 4'd0);
    step("b", 0, 0, ref_dec(4'hC, 4'd0));
    drv(1, 4'h0, 4'd1, 4'd2, 4'd7);
    branch_taken = 1'b1;
    step("b_taken", 0, 1, '0);
    branch_taken = 1'b0;
    step("b_after", 0, 0, ref_dec(4'h0, 4'd7));
    drv(1, 4'hC, 4'd0, 4'd0, 4'd0);
    step("b2", 0, 0, ref_dec(4'hC, 4'd0));
    drv(1, 4'h0, 4'd1, 4'd2, 4'd7);
    step("b_not", 0, 0, ref_dec(4'h0, 4'd7));

    drv(1, 4'h8, 4'd1, 4'd2, 4'd3);
    step("bz_lw", 0, 0, ref_dec(4'h8, 4'd3));
    drv(1, 4'hF, 4'd0, 4'd0, 4'd0);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step("busy_lu", 1, 0, '0);
    mem_busy = 1'b0;
    drv(1, 4'h0, 4'd3, 4'd4, 4'd6);
    step("rel_lu", 1, 0, '0);
    step("rel_go", 0, 0, ref_dec(4'h0, 4'd6));
    drv(1, 4'hC, 4'd0, 4'd0, 4'd0);
    step("b3", 0, 0, ref_dec(4'hC, 4'd0));
    drv(1, 4'h0, 4'd1, 4'd2, 4'd7);
    branch_taken = 1'b1;
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step("busy_br", 1, 0, '0);
    mem_busy = 1'b0;
    step("rel_br", 0, 1, '0);
    branch_taken = 1'b0;
    drv(0, 4'h0, 4'h0, 4'h0, 4'h0);
    step("rel_br2", 0, 0, '0);

    drv(1, 4'hF, 4'd0, 4'd0, 4'd0);
    exp_err = 1'b1;
    step("illeg", 0, 0, '0);
    drv(1, 4'h0, 4'd1, 4'd2, 4'd4);
    step("post_illeg", 0, 0, ref_dec(4'h0, 4'd4));
    drv(0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) step("illeg_hold", 0, 0, '0);
    do_reset("rst1");

    sel = 1'b0;
    do_reset("rst2");
    drv(1, 4'h0, 4'd1, 4'd2, 4'd5);
    step("f0_add", 0, 0, ref_dec(4'h0, 4'd5));
    drv(1, 4'h1, 4'd1, 4'd5, 4'd6);
    step("f0_s1", 1, 0, '0);
    step("f0_s2", 1, 0, '0);
    step("f0_go", 0, 0, ref_dec(4'h1, 4'd6));
    drv(1, 4'h0, 4'd1, 4'd2, 4'd5);
    step("f0_add2", 0, 0, ref_dec(4'h0, 4'd5));
    drv(1, 4'h3, 4'd1, 4'd2, 4'd7);
    step("f0_xor", 0, 0, ref_dec(4'h3, 4'd7));
    drv(1, 4'h1, 4'd5, 4'd8, 4'd9);
    step("f0_mem_s", 1, 0, '0);
    step("f0_mem_go", 0, 0, ref_dec(4'h1, 4'd9));
    drv(1, 4'h0, 4'd1, 4'd2, 4'd10);
    step("f0_add3", 0, 0, ref_dec(4'h0, 4'd10));
    drv(1, 4'hC, 4'd0, 4'd0, 4'd0);
    step("f0_b", 0, 0, ref_dec(4'hC, 4'd0));
    drv(1, 4'h1, 4'd10, 4'd2, 4'd11);
    branch_taken = 1'b1;
    step("f0_rh", 0, 1, '0);
    branch_taken = 1'b0;
    drv(0, 4'h0, 4'h0, 4'h0, 4'h0);
    step("f0_rh2", 0, 0, '0);
    for (int i = 0; i < 2; i++) step("f0_drain", 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
